// File: rtl/mux_pkg.sv
// Shared encodings for the 2:1 round-robin mux arbiter: FSM states and select values.
package mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT1 = 2'b01,
    S_GNT2 = 2'b10
  } state_t;

  localparam logic SEL_X1 = 1'b0;
  localparam logic SEL_X2 = 1'b1;

  function automatic logic other_sel(input logic sel);
    return (sel == SEL_X1) ? SEL_X2 : SEL_X1;
  endfunction

endpackage

// File: rtl/mux_2x1_bus.sv
// Combinational W-bit 2:1 mux; s=0 selects x1, s=1 selects x2.
module mux_2x1_bus #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         s,
  output logic [W-1:0] out
);

  assign out = s ? x2 : x1;

endmodule

// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin arbiter with burst lock sharing one valid/ready channel between two requesters.
// state  | meaning
// S_IDLE | no grant; arbitration bubble, out_sel holds its last value
// S_GNT1 | x1 owns the channel until last beat or MAX_BEATS accepted beats
// S_GNT2 | x2 owns the channel until last beat or MAX_BEATS accepted beats
module mux_2x1_rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid1,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              in_last1,
  output logic              out_ready1,
  input  logic              in_valid2,
  input  logic [DATA_W-1:0] in_data2,
  input  logic              in_last2,
  output logic              out_ready2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_f,
  output logic              out_last,
  input  logic              in_ready,
  output logic              out_sel,
  output logic              out_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  state_t           state;
  logic             ptr;
  logic             sel_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [DATA_W:0]  bus_out;
  logic             gnt1;
  logic             gnt2;
  logic             beat_ok;
  logic             beat_last;
  logic             burst_end;

  // last travels alongside data so one mux serves both
  mux_2x1_bus #(.W(DATA_W + 1)) u_bus (
    .x1  ({in_last1, in_data1}),
    .x2  ({in_last2, in_data2}),
    .s   (sel_q),
    .out (bus_out)
  );

  assign gnt1       = (state == S_GNT1);
  assign gnt2       = (state == S_GNT2);
  assign out_f      = bus_out[DATA_W-1:0];
  assign out_last   = bus_out[DATA_W];
  assign out_sel    = sel_q;
  assign out_busy   = gnt1 | gnt2;
  assign out_ready1 = gnt1 & in_ready;
  assign out_ready2 = gnt2 & in_ready;
  assign out_valid  = (gnt1 & in_valid1) | (gnt2 & in_valid2);

  assign beat_ok   = out_valid & in_ready;
  assign beat_last = gnt1 ? in_last1 : in_last2;
  assign burst_end = beat_ok & (beat_last | (beat_cnt == CNT_LAST));

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state    <= S_IDLE;
      sel_q    <= SEL_X1;
      ptr      <= SEL_X1;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid1 && (!in_valid2 || ptr == SEL_X1)) begin
            state <= S_GNT1;
            sel_q <= SEL_X1;
          end else if (in_valid2) begin
            state <= S_GNT2;
            sel_q <= SEL_X2;
          end
        end
        S_GNT1, S_GNT2: begin
          if (burst_end) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            ptr      <= other_sel(sel_q);
          end else if (beat_ok) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Bench for mux_2x1_rr_arbiter: directed vector table, hand sequences and random stimulus
// checked against a burst-level model, on a MAX_BEATS=4 and a MAX_BEATS=1 instance.
module tb_mux_2x1_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, v1, l1, v2, l2, rdy;
  logic [7:0] d1, d2;

  logic       va, la, r1a, r2a, sa, ba;
  logic [7:0] fa;
  logic       vb, lb, r1b, r2b, sb, bb;
  logic [7:0] fb;

  mux_2x1_rr_arbiter #(.DATA_W(8), .MAX_BEATS(4)) u_dut_a (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_valid1(v1), .in_data1(d1), .in_last1(l1), .out_ready1(r1a),
    .in_valid2(v2), .in_data2(d2), .in_last2(l2), .out_ready2(r2a),
    .out_valid(va), .out_f(fa), .out_last(la), .in_ready(rdy),
    .out_sel(sa), .out_busy(ba)
  );

  mux_2x1_rr_arbiter #(.DATA_W(8), .MAX_BEATS(1)) u_dut_b (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_valid1(v1), .in_data1(d1), .in_last1(l1), .out_ready1(r1b),
    .in_valid2(v2), .in_data2(d2), .in_last2(l2), .out_ready2(r2b),
    .out_valid(vb), .out_f(fb), .out_last(lb), .in_ready(rdy),
    .out_sel(sb), .out_busy(bb)
  );

  logic [13:0] pack_a, pack_b;
  assign pack_a = {va, la, fa, r1a, r2a, sa, ba};
  assign pack_b = {vb, lb, fb, r1b, r2b, sb, bb};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Burst-level model: owner 0 = none, 1 = x1, 2 = x2
  int   own[2];
  int   beats[2];
  int   prio[2];
  logic lsel[2];
  int   mx[2] = '{4, 1};
  bit   known = 1'b0;

  function automatic logic [13:0] model_out(input int k);
    logic s, v;
    s = (own[k] == 0) ? lsel[k] : (own[k] == 2);
    v = (own[k] == 1) ? v1 : (own[k] == 2) ? v2 : 1'b0;
    return {v, (s ? l2 : l1), (s ? d2 : d1), ((own[k] == 1) & rdy), ((own[k] == 2) & rdy),
            s, (own[k] != 0)};
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        own[k] = 0; beats[k] = 0; prio[k] = 1; lsel[k] = 1'b0;
      end else if (own[k] == 0) begin
        if (v1 && v2) own[k] = prio[k];
        else if (v1)  own[k] = 1;
        else if (v2)  own[k] = 2;
        if (own[k] != 0) lsel[k] = (own[k] == 2);
      end else if (((own[k] == 1) ? v1 : v2) && rdy) begin
        beats[k]++;
        if (((own[k] == 1) ? l1 : l2) || beats[k] == mx[k]) begin
          prio[k] = 3 - own[k];
          own[k] = 0;
          beats[k] = 0;
        end
      end
    end
    if (!rst_n) known = 1'b1;
  endtask

  task automatic step();
    #2;
    if (known) begin
      chk("model_a", pack_a, model_out(0));
      chk("model_b", pack_b, model_out(1));
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic rst_n, v1; logic [7:0] d1; logic l1, v2; logic [7:0] d2; logic l2, rdy;
    logic ev; logic [7:0] ef; logic el, er1, er2, es, eb;
  } vec_t;

  function automatic vec_t mk(input logic i_rst, i_v1, input logic [7:0] i_d1,
                              input logic i_l1, i_v2, input logic [7:0] i_d2,
                              input logic i_l2, i_rdy, e_v, input logic [7:0] e_f,
                              input logic e_l, e_r1, e_r2, e_s, e_b);
    vec_t r;
    r.rst_n = i_rst; r.v1 = i_v1; r.d1 = i_d1; r.l1 = i_l1;
    r.v2 = i_v2; r.d2 = i_d2; r.l2 = i_l2; r.rdy = i_rdy;
    r.ev = e_v; r.ef = e_f; r.el = e_l; r.er1 = e_r1; r.er2 = e_r2; r.es = e_s; r.eb = e_b;
    return r;
  endfunction

  vec_t tbl[$];
  logic [1:0] e6[6] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};

  initial begin
    // rst,v1,d1,l1, v2,d2,l2, rdy | valid,f,last, r1,r2, sel,busy   (checked on MAX_BEATS=4)
    tbl.push_back(mk(1,0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h11,0, 0,8'h00,0, 1, 0,8'h11,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h11,0, 0,8'h00,0, 1, 1,8'h11,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h12,0, 0,8'h00,0, 1, 1,8'h12,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h13,1, 0,8'h00,0, 1, 1,8'h13,1, 1,0, 0,1));
    tbl.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h21,0, 1,8'h31,0, 1, 0,8'h21,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h21,0, 1,8'h31,0, 1, 1,8'h21,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h22,1, 1,8'h31,0, 1, 1,8'h22,1, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h23,0, 1,8'h31,0, 1, 0,8'h23,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h23,0, 1,8'h31,0, 1, 1,8'h31,0, 0,1, 1,1));
    tbl.push_back(mk(1,1,8'h23,0, 1,8'h32,1, 1, 1,8'h32,1, 0,1, 1,1));
    tbl.push_back(mk(1,1,8'h23,0, 1,8'h33,0, 1, 0,8'h33,0, 0,0, 1,0));
    tbl.push_back(mk(1,1,8'h23,0, 1,8'h33,0, 1, 1,8'h23,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h24,1, 1,8'h33,0, 1, 1,8'h24,1, 1,0, 0,1));
    tbl.push_back(mk(1,0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h40,0, 0,8'h00,0, 1, 0,8'h40,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h40,0, 1,8'h50,0, 1, 1,8'h40,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h41,0, 1,8'h50,0, 1, 1,8'h41,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h42,0, 1,8'h50,0, 1, 1,8'h42,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h43,0, 1,8'h50,0, 1, 1,8'h43,0, 1,0, 0,1));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h50,0, 1, 0,8'h44,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h50,0, 1, 1,8'h50,0, 0,1, 1,1));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h51,0, 0, 1,8'h51,0, 0,0, 1,1));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h51,0, 1, 1,8'h51,0, 0,1, 1,1));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h52,0, 0, 1,8'h52,0, 0,0, 1,1));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h52,1, 1, 1,8'h52,1, 0,1, 1,1));
    tbl.push_back(mk(1,0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 1,0));

    rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0; l1 = 1'b0; l2 = 1'b0; d1 = '0; d2 = '0; rdy = 1'b1;
    step();

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; v1 = tbl[i].v1; d1 = tbl[i].d1; l1 = tbl[i].l1;
      v2 = tbl[i].v2; d2 = tbl[i].d2; l2 = tbl[i].l2; rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl[%0d]", i), pack_a,
          {tbl[i].ev, tbl[i].el, tbl[i].ef, tbl[i].er1, tbl[i].er2, tbl[i].es, tbl[i].eb});
      step();
    end

    // Reset in the middle of an x2 burst while the pointer favours x2
    v1 = 1'b1; d1 = 8'h60; l1 = 1'b1; v2 = 1'b0; rdy = 1'b1;
    step(); step();
    v1 = 1'b0; v2 = 1'b1; d2 = 8'h70; l2 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; v1 = 1'b1; l1 = 1'b0;
    #1;
    chk("rst_idle", {9'd0, va, ba, sa, r1a, r2a}, 14'd0);
    step();
    #1;
    chk("rst_ptr_x1", {10'd0, ba, sa, r1a, r2a}, 14'b1010);
    step();

    // Per-beat rotation on the MAX_BEATS=1 instance
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; v1 = 1'b1; v2 = 1'b1; l1 = 1'b0; l2 = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr1[%0d]", i), {12'd0, bb, sb}, {12'd0, e6[i]});
      step();
    end

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(63) != 0);
      v1    = ($urandom_range(3) != 0);
      v2    = ($urandom_range(3) != 0);
      l1    = ($urandom_range(4) == 0);
      l2    = ($urandom_range(4) == 0);
      d1    = 8'($urandom);
      d2    = 8'($urandom);
      rdy   = ($urandom_range(3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
